// File: rtl/sram_dma64.sv
// Block-copy initiator on the SRAM crossbar: read, capture, write per doubleword.
// Optional `SRAM_DMA_FILL_EN adds a pattern-fill mode (one write per doubleword).
module sram_dma64 #(
  parameter int LEN_ADDR = 64,
  parameter int LEN_DATA = 64,
  parameter int LEN_CNT  = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [LEN_ADDR-1:0]   src_addr,
  input  logic [LEN_ADDR-1:0]   dst_addr,
  input  logic [LEN_CNT-1:0]    len,
`ifdef SRAM_DMA_FILL_EN
  input  logic                  fill,
  input  logic [LEN_DATA-1:0]   fill_data,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [LEN_ADDR-1:0]   addra,
  output logic [LEN_DATA-1:0]   dina,
  input  logic [LEN_DATA-1:0]   douta,
  output logic                  ena,
  output logic [LEN_DATA/8-1:0] wea
);

  localparam int NB = LEN_DATA / 8;

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_CAP, S_WR, S_FIN
  } state_t;

  state_t              state_q, state_d;
  logic [LEN_ADDR-1:0] src_q, src_d;
  logic [LEN_ADDR-1:0] dst_q, dst_d;
  logic [LEN_CNT-1:0]  rem_q, rem_d;
  logic                bad_q, bad_d;
  logic                fill_q, fill_d;
  logic [LEN_DATA-1:0] fdat_q, fdat_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                ena_q, ena_d;
  logic [NB-1:0]       wea_q, wea_d;
  logic [LEN_ADDR-1:0] addra_q, addra_d;
  logic [LEN_DATA-1:0] dina_q, dina_d;

  logic                fill_w;
  logic [LEN_DATA-1:0] fdat_w;
  logic                mis;

`ifdef SRAM_DMA_FILL_EN
  assign fill_w = fill;
  assign fdat_w = fill_data;
`else
  assign fill_w = 1'b0;
  assign fdat_w = '0;
`endif

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    bad_d   = bad_q;
    fill_d  = fill_q;
    fdat_d  = fdat_q;
    dina_d  = dina_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    ena_d   = 1'b0;
    wea_d   = '0;
    addra_d = '0;
    mis     = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        src_d  = src_addr;
        dst_d  = dst_addr;
        rem_d  = len;
        fill_d = fill_w;
        fdat_d = fdat_w;
        mis    = (dst_addr[2:0] != 3'd0) ||
                 (!fill_w && src_addr[2:0] != 3'd0);
        bad_d  = mis;
        if (mis || len == '0) state_d = S_FIN;
        else if (fill_w)      state_d = S_WR;
        else                  state_d = S_RD;
      end
      S_RD:  state_d = S_CAP;
      S_CAP: begin
        dina_d  = douta;
        state_d = S_WR;
      end
      S_WR: begin
        src_d = src_q + LEN_ADDR'(8);
        dst_d = dst_q + LEN_ADDR'(8);
        rem_d = rem_q - LEN_CNT'(1);
        if (rem_q == LEN_CNT'(1)) state_d = S_FIN;
        else if (fill_q)          state_d = S_WR;
        else                      state_d = S_RD;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Bus outputs are registered from the state being entered.
    case (state_d)
      S_RD: begin
        ena_d   = 1'b1;
        addra_d = src_d;
        busy_d  = 1'b1;
      end
      S_CAP: busy_d = 1'b1;
      S_WR: begin
        ena_d   = 1'b1;
        wea_d   = '1;
        addra_d = dst_d;
        busy_d  = 1'b1;
        if (fill_d) dina_d = fdat_d;
      end
      S_FIN: begin
        done_d = 1'b1;
        err_d  = bad_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      bad_q   <= 1'b0;
      fill_q  <= 1'b0;
      fdat_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ena_q   <= 1'b0;
      wea_q   <= '0;
      addra_q <= '0;
      dina_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      bad_q   <= bad_d;
      fill_q  <= fill_d;
      fdat_q  <= fdat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ena_q   <= ena_d;
      wea_q   <= wea_d;
      addra_q <= addra_d;
      dina_q  <= dina_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;
  assign ena   = ena_q;
  assign wea   = wea_q;
  assign addra = addra_q;
  assign dina  = dina_q;

endmodule

// File: tb/tb_sram_dma64.sv
// Directed bench for sram_dma64: SRAM model, write scoreboard, latency checks.
// Define SRAM_DMA_FILL_EN to also exercise fill mode.
module tb_sram_dma64;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [63:0] src_addr, dst_addr;
  logic [15:0] len;
  logic        busy, done, err, ena;
  logic [63:0] addra, dina, douta;
  logic [7:0]  wea;
`ifdef SRAM_DMA_FILL_EN
  logic        fill;
  logic [63:0] fill_data;
`endif

  always #5 clk = ~clk;

  sram_dma64 dut (
    .clk(clk), .resetn(resetn), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
`ifdef SRAM_DMA_FILL_EN
    .fill(fill), .fill_data(fill_data),
`endif
    .busy(busy), .done(done), .err(err),
    .addra(addra), .dina(dina), .douta(douta),
    .ena(ena), .wea(wea)
  );

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] d;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         e;
  logic [63:0] mem [0:4095];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          rd_cnt, wr_cnt, dn_cnt, wc_cnt;
  logic        cnt_clr;
  logic        pl_we;
  logic [63:0] pl_addr, pl_data;

  function automatic logic [11:0] ix(input logic [63:0] a);
    return a[14:3];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // SRAM responder: synchronous read, full-doubleword writes
  always @(posedge clk) begin
    if (cnt_clr) wc_cnt <= 0;
    if (pl_we) mem[ix(pl_addr)] <= pl_data;
    else if (ena && wea != 8'h00) begin
      mem[ix(addra)] <= dina;
      wc_cnt <= wc_cnt + 1;
    end
    if (ena && wea == 8'h00) douta <= mem[ix(addra)];
  end

  always @(negedge clk) begin
    if (cnt_clr) begin
      rd_cnt <= 0;
      wr_cnt <= 0;
      dn_cnt <= 0;
    end else if (resetn) begin
      if (ena && wea == 8'h00) rd_cnt <= rd_cnt + 1;
      if (ena && wea != 8'h00) begin
        wr_cnt <= wr_cnt + 1;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $error("FAIL unexp_wr: observed write at %h expected none",
                 addra);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", addra, e.a);
          chk("wr_data", dina, e.d);
          chk("wr_wea", {56'h0, wea}, 64'hFF);
        end
      end
      if (done) dn_cnt <= dn_cnt + 1;
    end
  end

  task automatic preload(input logic [63:0] a, input logic [63:0] d);
    @(negedge clk);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic clr_counts();
    cnt_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1 cnt_clr = 1'b0;
  endtask

  task automatic push_copy(input logic [63:0] s, input logic [63:0] d,
                           input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back('{a: d + 64'(8*i), d: mem[ix(s + 64'(8*i))]});
  endtask

  // lat counts cycles inclusive: start cycle = 1, done cycle = lat
  task automatic run(input logic [63:0] s, input logic [63:0] d,
                     input logic [15:0] n, input logic ee, input int lat,
                     input int nrd, input int nwr, input int inj);
    int cnt;
    clr_counts();
    src_addr = s; dst_addr = d; len = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 1;
    if (lat > 2) chk("busy_run", {63'h0, busy}, 64'h1);
    while (!done && cnt < 300) begin
      @(negedge clk);
      cnt++;
      if (inj != 0 && cnt == inj) begin
        start = 1'b1; src_addr = 64'h8; dst_addr = 64'h400; len = 16'd1;
      end else start = 1'b0;
    end
    start = 1'b0;
    chk("latency", 64'(cnt + 1), 64'(lat));
    chk("done_err", {63'h0, err}, {63'h0, ee});
    chk("done_busy", {63'h0, busy}, 64'h0);
    @(negedge clk);
    #1;
    chk("done_pulse", {63'h0, done}, 64'h0);
    chk("rd_count", 64'(rd_cnt), 64'(nrd));
    chk("wr_count", 64'(wr_cnt), 64'(nwr));
    chk("done_count", 64'(dn_cnt), 64'h1);
    chk("sb_empty", 64'(exp_q.size()), 64'h0);
  endtask

  initial begin : stim
    logic found;
    resetn = 1'b0; start = 1'b0; cnt_clr = 1'b1; pl_we = 1'b0;
    src_addr = '0; dst_addr = '0; len = '0;
    pl_addr = '0; pl_data = '0;
`ifdef SRAM_DMA_FILL_EN
    fill = 1'b0; fill_data = 64'hDEADBEEFCAFEF00D;
`endif
    repeat (3) @(negedge clk);
    chk("rst_addra", addra, 64'h0);
    chk("rst_dina", dina, 64'h0);
    resetn = 1'b1;
    clr_counts();
    repeat (10) @(negedge clk);
    #1;
    chk("idle_ena", {63'h0, ena}, 64'h0);
    chk("idle_wea", {56'h0, wea}, 64'h0);
    chk("idle_busy", {63'h0, busy}, 64'h0);
    chk("idle_done", 64'(dn_cnt), 64'h0);

    preload(64'h0,  64'h1111111111111111);
    preload(64'h8,  64'h2222222222222222);
    preload(64'h10, 64'h3333333333333333);
    preload(64'h18, 64'h4444444444444444);
    preload(64'h508, 64'h5A5A5A5A5A5A5A5A);
    preload(64'hFFFF_FFFF_FFFF_FFF8, 64'hAAAAAAAAAAAAAAAA);

    push_copy(64'h0, 64'h100, 3);
    run(64'h0, 64'h100, 16'd3, 1'b0, 11, 3, 3, 0);
    chk("mem_108", mem[ix(64'h108)], 64'h2222222222222222);

    run(64'h0, 64'h300, 16'd0, 1'b0, 2, 0, 0, 0);
    run(64'h4, 64'h300, 16'd3, 1'b1, 2, 0, 0, 0);
    run(64'h0, 64'h301, 16'd3, 1'b1, 2, 0, 0, 0);

    push_copy(64'h0, 64'h200, 4);
    run(64'h0, 64'h200, 16'd4, 1'b0, 14, 4, 4, 5);

    exp_q.push_back('{a: 64'h700, d: 64'hAAAAAAAAAAAAAAAA});
    exp_q.push_back('{a: 64'h708, d: 64'h1111111111111111});
    run(64'hFFFF_FFFF_FFFF_FFF8, 64'h700, 16'd2, 1'b0, 8, 2, 2, 0);

    // abort on reset during the second write
    push_copy(64'h0, 64'h500, 1);
    clr_counts();
    src_addr = 64'h0; dst_addr = 64'h500; len = 16'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk);
      #1;
      if (ena && wea != 8'h00 && wc_cnt == 1) found = 1'b1;
    end
    chk("rst_reach", {63'h0, found}, 64'h1);
    resetn = 1'b0;
    #1;
    chk("abort_busy", {63'h0, busy}, 64'h0);
    chk("abort_done", {63'h0, done}, 64'h0);
    chk("abort_err", {63'h0, err}, 64'h0);
    chk("abort_ena", {63'h0, ena}, 64'h0);
    chk("abort_wea", {56'h0, wea}, 64'h0);
    chk("abort_addra", addra, 64'h0);
    chk("abort_dina", dina, 64'h0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    chk("abort_commits", 64'(wc_cnt), 64'h1);
    chk("abort_mem508", mem[ix(64'h508)], 64'h5A5A5A5A5A5A5A5A);
    chk("abort_nodone", 64'(dn_cnt), 64'h0);
    chk("abort_sb", 64'(exp_q.size()), 64'h0);

`ifdef SRAM_DMA_FILL_EN
    fill = 1'b1;
    exp_q.push_back('{a: 64'h6000_0000, d: 64'hDEADBEEFCAFEF00D});
    exp_q.push_back('{a: 64'h6000_0008, d: 64'hDEADBEEFCAFEF00D});
    run(64'h3, 64'h6000_0000, 16'd2, 1'b0, 4, 0, 2, 0);
    fill = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
